dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 32 +++
 rtl/dmem_arb_pick.sv | 64 ++++++
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               requester/owner encoding, arbiter FSM states, data width,
//               burst-counter width and grant-vector bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DATA_W = 32;

    // Burst counter wide enough for MAX_BURST up to 255.
    localparam int CNT_W = 8;

    // Bit positions inside the two-bit request / grant vectors.
    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_OWN   = 2'd1,
        DMA_BURST = 2'd2
    } state_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pick
// Description : Combinational winner selection for the dmem arbiter.
//               Inside a DMA burst the DMA owns the port until the burst
//               counter reaches MAX_BURST; at that bound a waiting CPU wins.
//               Outside a burst a lone requester wins, and a tie goes to the
//               requester named by the fairness pointer (the top level ties
//               the pointer to OWN_CPU when round-robin is not built).
// Ports       : reqs      in  2  {dma, cpu} requests, already reset-gated
//               state     in     current arbiter FSM state
//               burst_cnt in  8  DMA grants taken in the current burst
//               pointer   in     fairness pointer (tie winner)
//               grant     out 2  one-hot {dma, cpu} grant, or zero
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
)(
    input  logic [1:0]       reqs,
    input  state_t           state,
    input  logic [CNT_W-1:0] burst_cnt,
    input  owner_t           pointer,
    output logic [1:0]       grant
);

    localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);

    always_comb begin
        grant = 2'b00;
        if (state == DMA_BURST) begin
            if (burst_cnt < C_MAX_BURST) begin
                // Burst in progress: the CPU is locked out entirely.
                if (reqs[REQ_DMA]) begin
                    grant[REQ_DMA] = 1'b1;
                end
            end else begin
                // Starvation bound reached: a waiting CPU takes the port.
                if (reqs[REQ_CPU]) begin
                    grant[REQ_CPU] = 1'b1;
                end else if (reqs[REQ_DMA]) begin
                    grant[REQ_DMA] = 1'b1;
                end
            end
        end else begin
            case (reqs)
                2'b01:   grant[REQ_CPU] = 1'b1;
                2'b10:   grant[REQ_DMA] = 1'b1;
                2'b11: begin
                    if (pointer == OWN_DMA) begin
                        grant[REQ_DMA] = 1'b1;
                    end else begin
                        grant[REQ_CPU] = 1'b1;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

endmodule : dmem_arb_pick
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester (CPU, DMA) arbiter for a single-port
//               synchronous data memory with one-cycle read latency. Grants
//               are combinational and mean "accepted this cycle"; read data
//               is routed back to the owner one cycle later.
//               Build option: define DMEM_ARB_RR_EN to resolve simultaneous
//               non-burst requests round-robin; otherwise the CPU wins ties.
// Ports       : clk, rst (synchronous, active-low)
//               cpu_req/we/addr/wdata in, cpu_gnt/rvalid/rdata out
//               dma_req/we/addr/wdata/lock in, dma_gnt/rvalid/rdata out
//               dmem_en/we/addr/din out, dmem_dout in
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int ADDR_W    = 14
)(
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic [3:0]        dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              dmem_en,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_din,
    input  logic [DATA_W-1:0] dmem_dout
);

    localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
    logic             r_rst_done;
    logic             w_live;
    logic [1:0]       w_reqs;
    logic [1:0]       w_grant;
    owner_t           w_pointer;
    logic             w_rd_accept;
    logic             r_rsp_valid;
    owner_t           r_rsp_owner;
    logic             w_rsp_live;

    // Grants are suppressed while rst is low and for the first cycle after
    // it is released, so the port is guaranteed quiet across reset.
    assign w_live = rst & r_rst_done;
    assign w_reqs = {dma_req, cpu_req} & {2{w_live}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

`ifdef DMEM_ARB_RR_EN
    owner_t r_pointer;

    // Pointer names the requester that wins the next tie; it moves to the
    // other side after every grant and holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pointer <= OWN_CPU;
        end else if (w_grant[REQ_CPU]) begin
            r_pointer <= OWN_DMA;
        end else if (w_grant[REQ_DMA]) begin
            r_pointer <= OWN_CPU;
        end
    end

    assign w_pointer = r_pointer;
`else
    assign w_pointer = OWN_CPU;
`endif

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .reqs      (w_reqs),
        .state     (r_state),
        .burst_cnt (r_burst_cnt),
        .pointer   (w_pointer),
        .grant     (w_grant)
    );

    // ------------------------------------------------------------------
    // FSM: state and burst counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, burst count, grants and dmem port mux
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = IDLE;
        w_burst_cnt_nxt = '0;
        cpu_gnt         = w_grant[REQ_CPU];
        dma_gnt         = w_grant[REQ_DMA];
        dmem_en         = 1'b0;
        dmem_we         = 4'b0000;
        dmem_addr       = '0;
        dmem_din        = '0;

        if (w_grant[REQ_CPU]) begin
            dmem_en     = 1'b1;
            dmem_we     = cpu_we;
            dmem_addr   = cpu_addr;
            dmem_din    = cpu_wdata;
            w_state_nxt = CPU_OWN;
        end else if (w_grant[REQ_DMA]) begin
            dmem_en   = 1'b1;
            dmem_we   = dma_we;
            dmem_addr = dma_addr;
            dmem_din  = dma_wdata;
            if (dma_lock) begin
                w_state_nxt = DMA_BURST;
                // Saturate so a CPU arriving late still sees the bound.
                w_burst_cnt_nxt = (r_burst_cnt == C_MAX_BURST) ?
                                  C_MAX_BURST : r_burst_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-response pipeline: remember who issued the read, return the
    // memory data to that owner one cycle later.
    // ------------------------------------------------------------------
    assign w_rd_accept = dmem_en & (dmem_we == 4'b0000);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= OWN_CPU;
        end else begin
            r_rsp_valid <= w_rd_accept;
            r_rsp_owner <= w_grant[REQ_DMA] ? OWN_DMA : OWN_CPU;
        end
    end

    // A response in flight when reset asserts is dropped immediately.
    assign w_rsp_live = rst & r_rsp_valid;

    always_comb begin
        cpu_rvalid = w_rsp_live & (r_rsp_owner == OWN_CPU);
        dma_rvalid = w_rsp_live & (r_rsp_owner == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? dmem_dout : '0;
        dma_rdata  = dma_rvalid ? dmem_dout : '0;
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter (MAX_BURST=4).
//               Expected values are hand-computed; tie-break expectations
//               follow the DMEM_ARB_RR_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              dma_req;
    logic [3:0]        dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_lock;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;
    logic              dmem_en;
    logic [3:0]        dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_din;
    logic [31:0]       dmem_dout = 32'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MAX_BURST (4),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dmem_en    (dmem_en),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_dout  (dmem_dout)
    );

    // Memory contents seen by reads.
    function automatic logic [31:0] mem_data(input logic [ADDR_W-1:0] a);
        case (a)
            14'h0004: mem_data = 32'h0000_0011;
            14'h0008: mem_data = 32'h0000_0022;
            14'h0010: mem_data = 32'hDEAD_BEEF;
            default:  mem_data = 32'h0BAD_0000 | 32'(a);
        endcase
    endfunction

    // Synchronous single-port memory, one-cycle read latency.
    always @(posedge clk) begin
        if (dmem_en && dmem_we == 4'b0000) begin
            dmem_dout <= mem_data(dmem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (inputs are driven here).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic [3:0] we,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
    endtask

    task automatic drive_dma(input logic req, input logic [3:0] we,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                             input logic lock);
        dma_req   = req;
        dma_we    = we;
        dma_addr  = addr;
        dma_wdata = wd;
        dma_lock  = lock;
    endtask

    initial begin
        logic exp_cpu;
        rst = 1'b0;
        drive_cpu(1'b0, 4'h0, '0, 32'h0);
        drive_dma(1'b0, 4'h0, '0, 32'h0, 1'b0);

        // ---------------- reset: requests present but nothing granted
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive_cpu(1'b1, 4'h0, 14'h0010, 32'h0);
            drive_dma(1'b1, 4'h0, 14'h0008, 32'h0, 1'b1);
            #1;
            chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
            chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
            chk("rst_dmem_en", 32'(dmem_en), 32'd0);
            chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        end

        // ---------------- first cycle after reset: still quiet
        next_cycle();
        rst = 1'b1;
        #1;
        chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("post_rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("post_rst_dmem_en", 32'(dmem_en), 32'd0);
        chk("post_rst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
        chk("post_rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("post_rst_burst_cnt", 32'(dut.r_burst_cnt), 32'd0);

        // ---------------- simultaneous single (unlocked) writes, 4 cycles
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_cpu(1'b1, 4'hF, 14'h0100, 32'h1111_0000);
            drive_dma(1'b1, 4'hF, 14'h0200, 32'h2222_0000, 1'b0);
            #1;
`ifdef DMEM_ARB_RR_EN
            exp_cpu = (i % 2 == 0);
`else
            exp_cpu = 1'b1;
`endif
            chk("tie_cpu_gnt", 32'(cpu_gnt), 32'(exp_cpu));
            chk("tie_dma_gnt", 32'(dma_gnt), 32'(!exp_cpu));
            chk("tie_dmem_addr", 32'(dmem_addr), exp_cpu ? 32'h100 : 32'h200);
        end

        // ---------------- CPU-only read of 0x0010
        next_cycle();
        drive_cpu(1'b1, 4'h0, 14'h0010, 32'h0);
        drive_dma(1'b0, 4'h0, '0, 32'h0, 1'b0);
        #1;
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rd_dmem_en", 32'(dmem_en), 32'd1);
        chk("rd_dmem_we", 32'(dmem_we), 32'd0);
        chk("rd_dmem_addr", 32'(dmem_addr), 32'h10);
        next_cycle();
        drive_cpu(1'b0, 4'h0, '0, 32'h0);
        #1;
        chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rd_dma_rdata", dma_rdata, 32'd0);
        chk("idle_dmem_en", 32'(dmem_en), 32'd0);

        // ---------------- interleaved reads: CPU 0x0004 then DMA 0x0008
        next_cycle();
        drive_cpu(1'b1, 4'h0, 14'h0004, 32'h0);
        #1;
        chk("il_cpu_gnt", 32'(cpu_gnt), 32'd1);
        next_cycle();
        drive_cpu(1'b0, 4'h0, '0, 32'h0);
        drive_dma(1'b1, 4'h0, 14'h0008, 32'h0, 1'b0);
        #1;
        chk("il_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("il_dmem_addr", 32'(dmem_addr), 32'h8);
        chk("il_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("il_cpu_rdata", cpu_rdata, 32'h11);
        chk("il_dma_rvalid0", 32'(dma_rvalid), 32'd0);
        next_cycle();
        drive_dma(1'b0, 4'h0, '0, 32'h0, 1'b0);
        #1;
        chk("il_dma_rvalid", 32'(dma_rvalid), 32'd1);
        chk("il_dma_rdata", dma_rdata, 32'h22);
        chk("il_cpu_rvalid1", 32'(cpu_rvalid), 32'd0);
        chk("il_cpu_rdata1", cpu_rdata, 32'd0);

        // ---------------- CPU write
        next_cycle();
        drive_cpu(1'b1, 4'b0011, 14'h0020, 32'h0000_A5A5);
        #1;
        chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr_dmem_we", 32'(dmem_we), 32'h3);
        chk("wr_dmem_addr", 32'(dmem_addr), 32'h20);
        chk("wr_dmem_din", dmem_din, 32'h0000_A5A5);
        next_cycle();
        drive_cpu(1'b0, 4'h0, '0, 32'h0);
        #1;
        chk("wr_no_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);

        // ---------------- locked DMA burst, CPU arrives at cycle 2
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive_dma(1'b1, 4'hF, 14'h0030, 32'h0000_3000 + 32'(i), 1'b1);
            drive_cpu(i >= 2, 4'h0, 14'h0004, 32'h0);
            #1;
            chk("burst_dma_gnt", 32'(dma_gnt), 32'(i < 4));
            chk("burst_cpu_gnt", 32'(cpu_gnt), 32'(i == 4));
            if (i == 4) begin
                chk("burst_cnt_at_bound", 32'(dut.r_burst_cnt), 32'd4);
            end
        end
        next_cycle();
        drive_cpu(1'b0, 4'h0, '0, 32'h0);
        drive_dma(1'b0, 4'h0, '0, 32'h0, 1'b0);
        #1;
        chk("burst_cnt_cleared", 32'(dut.r_burst_cnt), 32'd0);
        chk("burst_state_cpu", 32'(dut.r_state), 32'(CPU_OWN));
        chk("burst_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("burst_cpu_rdata", cpu_rdata, 32'h11);
        next_cycle();
        #1;
        chk("burst_state_idle", 32'(dut.r_state), 32'(IDLE));

        // ---------------- reset while a DMA read is in flight
        next_cycle();
        drive_dma(1'b1, 4'h0, 14'h0008, 32'h0, 1'b0);
        #1;
        chk("mid_dma_gnt", 32'(dma_gnt), 32'd1);
        next_cycle();
        rst = 1'b0;
        drive_dma(1'b0, 4'h0, '0, 32'h0, 1'b0);
        #1;
        chk("mid_rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("mid_rst_dma_rdata", dma_rdata, 32'd0);
        chk("mid_rst_dmem_en", 32'(dmem_en), 32'd0);
        next_cycle();
        rst = 1'b1;
        drive_dma(1'b1, 4'h0, 14'h0008, 32'h0, 1'b0);
        #1;
        chk("mid_after_state", 32'(dut.r_state), 32'(IDLE));
        chk("mid_after_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("mid_after_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
        chk("mid_after_data", cpu_rdata | dma_rdata | dmem_din, 32'd0);
        next_cycle();
        drive_dma(1'b0, 4'h0, '0, 32'h0, 1'b0);
        #1;
        chk("mid_late_dma_rvalid", 32'(dma_rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
